// File: rtl/beat_sequencer.sv
// beat_sequencer: prescaled beat index with STOP/PLAY/PAUSE/DONE control feeding the music ROM.
// Optional seek (+/-16 beats) is compiled in with `define BEAT_SEQ_SEEK_EN.
module beat_sequencer #(
  parameter int LEN         = 512,
  parameter int TICK_DIV    = 4194304,
  parameter int SLOW_FACTOR = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        play_i,
  input  logic        slow_i,
  input  logic        loop_i,
  input  logic        music_sel_i,
`ifdef BEAT_SEQ_SEEK_EN
  input  logic        seek_fwd_i,
  input  logic        seek_back_i,
`endif
  output logic [11:0] ibeat_o,
  output logic        en_o,
  output logic        beat_tick_o,
  output logic        song_end_o
);

  localparam int              SCW       = (SLOW_FACTOR > 1) ? $clog2(SLOW_FACTOR) : 1;
  localparam logic [11:0]     LAST      = 12'(LEN - 1);
  localparam logic [31:0]     PRE_LAST  = 32'(TICK_DIV - 1);
  localparam logic [SCW-1:0]  SLOW_LAST = SCW'(SLOW_FACTOR - 1);

  typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_PAUSE, ST_DONE} state_t;

  state_t         state_q, state_d;
  logic [11:0]    ibeat_q, ibeat_d;
  logic [31:0]    presc_q, presc_d;
  logic [SCW-1:0] slow_cnt_q, slow_cnt_d;
  logic           sel_q, sel_vld_q;
  logic           en_q, en_d;
  logic           tick_q, tick_d;
  logic           end_q, end_d;
  logic           sel_chg, terminal, advance;

  // sel_vld_q masks the first sample after reset so it is not seen as a song change
  assign sel_chg  = sel_vld_q && (music_sel_i != sel_q);
  assign terminal = (state_q == ST_PLAY) && (presc_q == PRE_LAST);
  assign advance  = terminal && (!slow_i || (slow_cnt_q == SLOW_LAST));

`ifdef BEAT_SEQ_SEEK_EN
  logic        seek_ok;
  logic [12:0] fwd_sum;
  logic [11:0] fwd_val, back_val;

  assign seek_ok  = ((state_q == ST_PLAY) || (state_q == ST_PAUSE)) && !sel_chg &&
                    (seek_fwd_i ^ seek_back_i);
  assign fwd_sum  = {1'b0, ibeat_q} + 13'd16;
  assign fwd_val  = (fwd_sum > {1'b0, LAST}) ? LAST : fwd_sum[11:0];
  assign back_val = (ibeat_q < 12'd16) ? 12'd0 : (ibeat_q - 12'd16);
`endif

  always_comb begin
    state_d    = state_q;
    ibeat_d    = ibeat_q;
    presc_d    = presc_q;
    slow_cnt_d = slow_cnt_q;
    tick_d     = 1'b0;
    end_d      = 1'b0;

    if (sel_chg) begin
      state_d    = ST_STOP;
      ibeat_d    = '0;
      presc_d    = '0;
      slow_cnt_d = '0;
    end else begin
      case (state_q)
        ST_STOP: begin
          ibeat_d    = '0;
          presc_d    = '0;
          slow_cnt_d = '0;
          if (play_i) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (!play_i) state_d = ST_PAUSE;
          presc_d = (presc_q == PRE_LAST) ? '0 : (presc_q + 32'd1);
          if (advance) begin
            slow_cnt_d = '0;
            end_d      = (ibeat_q == LAST);
            if (ibeat_q != LAST) begin
              ibeat_d = ibeat_q + 12'd1;
              tick_d  = 1'b1;
            end else if (loop_i) begin
              ibeat_d = '0;
              tick_d  = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end else if (!slow_i) begin
            slow_cnt_d = '0;
          end else if (terminal) begin
            slow_cnt_d = slow_cnt_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (play_i) state_d = ST_PLAY;
        end
        ST_DONE: begin
          ibeat_d    = LAST;
          presc_d    = '0;
          slow_cnt_d = '0;
          if (!play_i) begin
            state_d = ST_STOP;
            ibeat_d = '0;
          end
        end
        default: state_d = ST_STOP;
      endcase

`ifdef BEAT_SEQ_SEEK_EN
      // a seek replaces any advance in the same cycle and restarts the beat period
      if (seek_ok) begin
        state_d    = play_i ? ST_PLAY : ST_PAUSE;
        ibeat_d    = seek_fwd_i ? fwd_val : back_val;
        presc_d    = '0;
        slow_cnt_d = '0;
        tick_d     = 1'b0;
        end_d      = 1'b0;
      end
`endif
    end

    en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_STOP;
      ibeat_q    <= '0;
      presc_q    <= '0;
      slow_cnt_q <= '0;
      sel_q      <= 1'b0;
      sel_vld_q  <= 1'b0;
      en_q       <= 1'b0;
      tick_q     <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ibeat_q    <= ibeat_d;
      presc_q    <= presc_d;
      slow_cnt_q <= slow_cnt_d;
      sel_q      <= music_sel_i;
      sel_vld_q  <= 1'b1;
      en_q       <= en_d;
      tick_q     <= tick_d;
      end_q      <= end_d;
    end
  end

  assign ibeat_o     = ibeat_q;
  assign en_o        = en_q;
  assign beat_tick_o = tick_q;
  assign song_end_o  = end_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer; beat events are scored against a queue of expected events.
`timescale 1ns/1ps
module tb_beat_sequencer;

`ifdef BEAT_SEQ_SEEK_EN
  localparam int LEN = 64;
`else
  localparam int LEN = 8;
`endif
  localparam int TD = 4;
  localparam int SF = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni, play_i, slow_i, loop_i, music_sel_i;
  logic [11:0] ibeat_o;
  logic        en_o, beat_tick_o, song_end_o;
`ifdef BEAT_SEQ_SEEK_EN
  logic        seek_fwd_i, seek_back_i;
`endif

  typedef struct packed {
    logic [11:0] ibeat;
    logic        tick;
    logic        send;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk_i = ~clk_i;

  beat_sequencer #(.LEN(LEN), .TICK_DIV(TD), .SLOW_FACTOR(SF)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .play_i      (play_i),
    .slow_i      (slow_i),
    .loop_i      (loop_i),
    .music_sel_i (music_sel_i),
`ifdef BEAT_SEQ_SEEK_EN
    .seek_fwd_i  (seek_fwd_i),
    .seek_back_i (seek_back_i),
`endif
    .ibeat_o     (ibeat_o),
    .en_o        (en_o),
    .beat_tick_o (beat_tick_o),
    .song_end_o  (song_end_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [11:0] b, input logic t, input logic s);
    ev_t e;
    e.ibeat = b;
    e.tick  = t;
    e.send  = s;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // every beat_tick/song_end pulse must match the oldest expected event
  always @(posedge clk_i) begin : mon
    ev_t e;
    #2;
    if (rst_ni === 1'b1 && (beat_tick_o === 1'b1 || song_end_o === 1'b1)) begin
      check("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_ibeat", 32'(ibeat_o), 32'(e.ibeat));
        check("sb_tick",  32'(beat_tick_o), 32'(e.tick));
        check("sb_end",   32'(song_end_o), 32'(e.send));
      end
    end
  end

  initial begin
    rst_ni = 1'b0; play_i = 1'b0; slow_i = 1'b0; loop_i = 1'b1; music_sel_i = 1'b0;
`ifdef BEAT_SEQ_SEEK_EN
    seek_fwd_i = 1'b0; seek_back_i = 1'b0;
`endif
    wait_n(3);
    check("rst_ibeat", 32'(ibeat_o), 0);
    check("rst_en",    32'(en_o), 0);
    check("rst_tick",  32'(beat_tick_o), 0);
    check("rst_end",   32'(song_end_o), 0);
    rst_ni = 1'b1;
    tick();
    check("stop_en", 32'(en_o), 0);

    // basic looping play
    for (int b = 1; b < LEN; b++) push(12'(b), 1'b1, 1'b0);
    push(12'd0, 1'b1, 1'b1);
    play_i = 1'b1;
    tick();
    check("play_en", 32'(en_o), 1);
    check("play_ibeat0", 32'(ibeat_o), 0);
    wait_n(TD - 1);
    check("beat0_hold", 32'(ibeat_o), 0);
    tick();
    check("beat1", 32'(ibeat_o), 1);
    check("beat1_tick", 32'(beat_tick_o), 1);
    tick();
    check("tick_single", 32'(beat_tick_o), 0);
    wait_n(TD * LEN - TD - 1);
    check("wrap_ibeat", 32'(ibeat_o), 0);
    check("wrap_end", 32'(song_end_o), 1);
    check("wrap_tick", 32'(beat_tick_o), 1);

    // slow playback, then slow released mid-beat
    slow_i = 1'b1;
    push(12'd1, 1'b1, 1'b0);
    push(12'd2, 1'b1, 1'b0);
    push(12'd3, 1'b1, 1'b0);
    wait_n(TD * SF - 1);
    check("slow_hold", 32'(ibeat_o), 0);
    tick();
    check("slow_beat1", 32'(ibeat_o), 1);
    wait_n(TD * SF);
    check("slow_beat2", 32'(ibeat_o), 2);
    wait_n(TD + 2);
    slow_i = 1'b0;
    tick();
    check("slow_off_hold", 32'(ibeat_o), 2);
    tick();
    check("slow_off_beat", 32'(ibeat_o), 3);

    // pause with prescaler at 2
    wait_n(2);
    play_i = 1'b0;
    push(12'd4, 1'b1, 1'b0);
    tick();
    check("pause_en", 32'(en_o), 0);
    check("pause_ibeat", 32'(ibeat_o), 3);
    wait_n(20);
    check("pause_hold_ibeat", 32'(ibeat_o), 3);
    check("pause_hold_en", 32'(en_o), 0);
    play_i = 1'b1;
    tick();
    check("resume_en", 32'(en_o), 1);
    check("resume_hold", 32'(ibeat_o), 3);
    tick();
    check("resume_beat", 32'(ibeat_o), 4);

    // one-shot end
    loop_i = 1'b0;
    for (int b = 5; b < LEN; b++) push(12'(b), 1'b1, 1'b0);
    push(12'(LEN - 1), 1'b0, 1'b1);
    wait_n(TD * (LEN - 4) - 1);
    check("last_beat", 32'(ibeat_o), LEN - 1);
    tick();
    check("done_end", 32'(song_end_o), 1);
    check("done_notick", 32'(beat_tick_o), 0);
    check("done_ibeat", 32'(ibeat_o), LEN - 1);
    check("done_en", 32'(en_o), 0);
    wait_n(3);
    check("done_hold", 32'(ibeat_o), LEN - 1);
    play_i = 1'b0;
    tick();
    check("done_stop_ibeat", 32'(ibeat_o), 0);
    check("done_stop_en", 32'(en_o), 0);

    // song change at beat 5
    loop_i = 1'b1;
    play_i = 1'b1;
    for (int b = 1; b <= 5; b++) push(12'(b), 1'b1, 1'b0);
    tick();
    check("replay_en", 32'(en_o), 1);
    wait_n(5 * TD);
    check("sel_at5", 32'(ibeat_o), 5);
    music_sel_i = 1'b1;
    push(12'd1, 1'b1, 1'b0);
    tick();
    check("sel_restart", 32'(ibeat_o), 0);
    check("sel_en", 32'(en_o), 0);
    tick();
    check("sel_replay_en", 32'(en_o), 1);
    wait_n(TD - 1);
    check("sel_replay_hold", 32'(ibeat_o), 0);
    tick();
    check("sel_replay_beat1", 32'(ibeat_o), 1);

    // asynchronous reset mid-beat
    wait_n(2);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_ibeat", 32'(ibeat_o), 0);
    check("arst_en", 32'(en_o), 0);
    play_i = 1'b0;
    wait_n(2);
    rst_ni = 1'b1;
    tick();
    check("post_rst_en", 32'(en_o), 0);

`ifdef BEAT_SEQ_SEEK_EN
    play_i = 1'b1;
    for (int b = 1; b <= 55; b++) push(12'(b), 1'b1, 1'b0);
    tick();
    wait_n(55 * TD);
    check("seek_at55", 32'(ibeat_o), 55);
    seek_fwd_i = 1'b1;
    tick();
    seek_fwd_i = 1'b0;
    check("seek_fwd", 32'(ibeat_o), 63);
    check("seek_notick", 32'(beat_tick_o), 0);
    seek_back_i = 1'b1;
    tick();
    seek_back_i = 1'b0;
    check("seek_back1", 32'(ibeat_o), 47);
    seek_back_i = 1'b1;
    tick();
    seek_back_i = 1'b0;
    check("seek_back2", 32'(ibeat_o), 31);
    seek_fwd_i = 1'b1;
    seek_back_i = 1'b1;
    tick();
    seek_fwd_i = 1'b0;
    seek_back_i = 1'b0;
    check("seek_both", 32'(ibeat_o), 31);
    play_i = 1'b0;
    tick();
`endif

    wait_n(2);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
